// File: rtl/str_sender_param.sv
// ============================================================================
// str_sender_param : fixed-string byte streamer on a valid/ready interface.
// Optional trailing CR/LF per message when STR_SENDER_CRLF_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

module str_sender_param #(
  parameter int               LEN  = 35,
  parameter logic [8*LEN-1:0] STR  = "19/08/2005: 0x5F3759DF = 1597463007",
  parameter bit               LOOP = 1'b1,
  parameter int               GAP  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  s_dtm,
  output logic        s_vld,
  input  logic        s_rdy,
  output logic        s_last,
  output logic        busy,
  output logic [15:0] msg_cnt
);

`ifdef STR_SENDER_CRLF_EN
  localparam int c_msg_len = LEN + 2;
`else
  localparam int c_msg_len = LEN;
`endif
  localparam int                 c_idx_w    = $clog2(LEN + 2);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_msg_len - 1);
  localparam logic               c_single   = (c_msg_len == 1);
  localparam logic [7:0]         c_gap      = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [7:0]           r_gap_cnt;
  logic [15:0]          r_msg_cnt;
  logic [7:0]           r_dtm;
  logic                 r_vld;
  logic                 r_last;
  logic [c_idx_w-1:0]   w_idx_inc;

  // Character i of the message, leftmost STR character first.
  function automatic logic [7:0] char_at(input logic [c_idx_w-1:0] i);
    logic [8*LEN-1:0] sh;
    sh = STR << {i, 3'b000};
`ifdef STR_SENDER_CRLF_EN
    if (i == c_idx_w'(LEN))     return 8'h0D;
    if (i == c_idx_w'(LEN + 1)) return 8'h0A;
`endif
    return sh[8*LEN-1 -: 8];
  endfunction

  assign w_idx_inc = r_idx + c_idx_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_msg_cnt <= '0;
      r_dtm     <= char_at('0);
      r_vld     <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (LOOP || start) begin
            r_state <= S_SEND;
            r_idx   <= '0;
            r_dtm   <= char_at('0);
            r_vld   <= 1'b1;
            r_last  <= c_single;
          end
        end
        S_SEND: begin
          if (s_rdy) begin
            if (r_idx != c_last_idx) begin
              r_idx  <= w_idx_inc;
              r_dtm  <= char_at(w_idx_inc);
              r_last <= (w_idx_inc == c_last_idx);
            end else begin
              r_idx     <= '0;
              r_dtm     <= char_at('0);
              r_msg_cnt <= r_msg_cnt + 16'd1;
              if (GAP > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= c_gap;
                r_vld     <= 1'b0;
                r_last    <= 1'b0;
              end else if (LOOP) begin
                r_last <= c_single;
              end else begin
                r_state <= S_IDLE;
                r_vld   <= 1'b0;
                r_last  <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          // The counter value 1 marks the final idle cycle.
          if (r_gap_cnt <= 8'd1) begin
            r_gap_cnt <= '0;
            if (LOOP) begin
              r_state <= S_SEND;
              r_vld   <= 1'b1;
              r_last  <= c_single;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_vld   <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign s_dtm   = r_dtm;
  assign s_vld   = r_vld;
  assign s_last  = r_last;
  assign busy    = (r_state != S_IDLE);
  assign msg_cnt = r_msg_cnt;

endmodule

`default_nettype wire
